pwm_gen_core: RTL and testbench

Downstream consumer of the pwmcore AXI4-Lite slave register file (four 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC). It turns the programmed control, period, duty and prescale values into a glitch-free PWM waveform. Register changes are applied only at period boundaries through shadow registers. The block also reports period-end ticks and its run status back to the register file for readback.

---
 rtl/pwm_gen_core.sv | 146 ++++++++++++++
 tb/tb_pwm_gen_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_core.sv
// PWM generator with shadowed period/duty/prescale, one-shot mode and status readback.
// Register updates are applied only at period boundaries so the output never glitches.
module pwm_gen_core #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          ctrl_reg,
  input  logic [CNT_WIDTH-1:0] period_reg,
  input  logic [CNT_WIDTH-1:0] duty_reg,
  input  logic [31:0]          prescale_reg,
  input  logic                 update_req,
  output logic                 pwm_out,
  output logic                 period_tick,
  output logic [CNT_WIDTH-1:0] cnt_value,
  output logic                 running,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_WIDTH-1:0] per_s_q, per_s_d;
  logic [CNT_WIDTH-1:0] duty_s_q, duty_s_d;
  logic [PRE_WIDTH-1:0] pre_s_q, pre_s_d;
  logic                 upd_pend_q, upd_pend_d;
  logic                 pwm_q, pwm_d;
  logic                 tick_out_q, tick_out_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;

  logic enable, invert, one_shot;
  logic tick, wrap;
  logic unused_bits;

  assign enable   = ctrl_reg[0];
  assign invert   = ctrl_reg[1];
  assign one_shot = ctrl_reg[2];
  assign unused_bits = ^{ctrl_reg[31:3], prescale_reg[31:PRE_WIDTH]};

  assign tick = (pre_cnt_q == pre_s_q);
  assign wrap = tick && (cnt_q == per_s_q);

  // Next-state, counters, shadow registers and registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_cnt_d  = pre_cnt_q;
    per_s_d    = per_s_q;
    duty_s_d   = duty_s_q;
    pre_s_d    = pre_s_q;
    upd_pend_d = upd_pend_q;
    pwm_d      = invert;
    tick_out_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        per_s_d    = period_reg;
        duty_s_d   = duty_reg;
        pre_s_d    = prescale_reg[PRE_WIDTH-1:0];
        upd_pend_d = 1'b0;
        cnt_d      = '0;
        pre_cnt_d  = '0;
        if (state_q == ST_IDLE && enable) begin
          state_d = ST_RUN;
        end else if (state_q == ST_DONE && !enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pre_cnt_d = '0;
        end else begin
          pwm_d      = (cnt_q < duty_s_q) ^ invert;
          upd_pend_d = upd_pend_q | update_req;
          pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_WIDTH'(1);
          if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
          end
          if (wrap) begin
            tick_out_d = 1'b1;
            // A request landing on the wrap cycle itself is honoured here
            if (upd_pend_q || update_req) begin
              per_s_d    = period_reg;
              duty_s_d   = duty_reg;
              pre_s_d    = prescale_reg[PRE_WIDTH-1:0];
              upd_pend_d = 1'b0;
            end
            if (one_shot) begin
              state_d = ST_DONE;
              pwm_d   = invert;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pre_cnt_q  <= '0;
      per_s_q    <= '0;
      duty_s_q   <= '0;
      pre_s_q    <= '0;
      upd_pend_q <= 1'b0;
      pwm_q      <= 1'b0;
      tick_out_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      per_s_q    <= per_s_d;
      duty_s_q   <= duty_s_d;
      pre_s_q    <= pre_s_d;
      upd_pend_q <= upd_pend_d;
      pwm_q      <= pwm_d;
      tick_out_q <= tick_out_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_out_q;
  assign cnt_value   = cnt_q;
  assign running     = running_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pwm_gen_core.sv
// Bench for pwm_gen_core: directed scenarios plus random register traffic checked
// every clock against an elapsed-clocks reference model.
module tb_pwm_gen_core;

  localparam int unsigned CW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   ctrl_reg;
  logic [CW-1:0] period_reg;
  logic [CW-1:0] duty_reg;
  logic [31:0]   prescale_reg;
  logic          update_req;
  logic          pwm_out;
  logic          period_tick;
  logic [CW-1:0] cnt_value;
  logic          running;
  logic          done;

  pwm_gen_core #(.CNT_WIDTH(CW), .PRE_WIDTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_reg     (ctrl_reg),
    .period_reg   (period_reg),
    .duty_reg     (duty_reg),
    .prescale_reg (prescale_reg),
    .update_req   (update_req),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .cnt_value    (cnt_value),
    .running      (running),
    .done         (done)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: position in the period is tracked as elapsed clocks k,
  // so counter value is k/(pre+1) and a period lasts (per+1)*(pre+1) clocks.
  bit              m_run, m_done, m_pend, m_pwm, m_tick;
  longint unsigned m_k, m_per, m_duty, m_pre;

  function automatic longint unsigned m_cnt();
    return m_k / (m_pre + 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pend = 0; m_pwm = 0; m_tick = 0;
    m_k = 0; m_per = 0; m_duty = 0; m_pre = 0;
  endtask

  task automatic model_load();
    m_per  = period_reg;
    m_duty = duty_reg;
    m_pre  = prescale_reg[15:0];
  endtask

  task automatic model_step();
    bit en, inv, os;
    en = ctrl_reg[0]; inv = ctrl_reg[1]; os = ctrl_reg[2];
    m_tick = 0;
    if (!m_run) begin
      model_load();
      m_pend = 0; m_k = 0; m_pwm = inv;
      if (m_done) begin
        if (!en) m_done = 0;
      end else if (en) begin
        m_run = 1;
      end
    end else if (!en) begin
      m_run = 0; m_k = 0; m_pwm = inv;
    end else begin
      m_pwm  = (m_cnt() < m_duty) ^ inv;
      m_pend = m_pend | update_req;
      if (m_k == (m_per + 1) * (m_pre + 1) - 1) begin
        m_tick = 1; m_k = 0;
        if (m_pend) begin model_load(); m_pend = 0; end
        if (os) begin m_run = 0; m_done = 1; m_pwm = inv; end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic compare_all();
    check("pwm_out", 64'(pwm_out), 64'(m_pwm));
    check("period_tick", 64'(period_tick), 64'(m_tick));
    check("cnt_value", 64'(cnt_value), 64'(m_cnt()));
    check("running", 64'(running), 64'(m_run));
    check("done", 64'(done), 64'(m_done));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    case (idx)
      1: period_reg = val;
      2: duty_reg = val;
      default: prescale_reg = val;
    endcase
    update_req = 1'b1;
    cycle();
    update_req = 1'b0;
  endtask

  task automatic configure(input logic [31:0] c, input logic [31:0] p, input logic [31:0] d,
                           input logic [31:0] s);
    ctrl_reg = 32'h0;
    cycles(2);
    period_reg = p; duty_reg = d; prescale_reg = s;
    cycle();
    ctrl_reg = c;
  endtask

  task automatic wait_cnt(input string tag, input longint unsigned target);
    int i;
    i = 0;
    while (!(m_run && m_cnt() == target) && i < 300) begin
      cycle();
      i++;
    end
    if (i >= 300) check(tag, 64'(cnt_value), 64'(target));
  endtask

  initial begin
    reset = 1'b1; ctrl_reg = '0; period_reg = '0; duty_reg = '0;
    prescale_reg = '0; update_req = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Basic waveform, then prescaled waveform
    configure(32'h1, 4, 2, 0);
    cycles(22);
    configure(32'h1, 3, 1, 2);
    cycles(40);

    // Shadow update mid-period
    configure(32'h1, 9, 5, 0);
    cycles(12);
    wait_cnt("wait_cnt3", 3);
    write_reg(2, 2);
    cycles(25);

    // Edge duties and invert
    configure(32'h1, 4, 0, 0);
    cycles(12);
    configure(32'h1, 4, 10, 0);
    cycles(12);
    ctrl_reg = 32'h3;
    cycles(12);
    ctrl_reg = 32'h2;
    cycles(4);
    check("inv_idle_level", 64'(pwm_out), 64'h1);

    // One-shot
    configure(32'h5, 2, 1, 0);
    cycles(10);
    check("oneshot_done", 64'(done), 64'h1);
    ctrl_reg = 32'h4;
    cycles(3);

    // Asynchronous reset mid-period
    configure(32'h1, 9, 5, 0);
    wait_cnt("wait_cnt2", 2);
    #3 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2 reset = 1'b0;
    cycles(15);

    // Random register traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(59) == 0) begin
        ctrl_reg = {29'h0, ($urandom_range(9) == 0), 1'($urandom_range(1)),
                    ($urandom_range(7) != 0)};
      end
      if ($urandom_range(14) == 0) begin
        case ($urandom_range(2))
          0: write_reg(1, 32'($urandom_range(7)));
          1: write_reg(2, 32'($urandom_range(10)));
          default: write_reg(3, 32'($urandom_range(3)) | (32'($urandom_range(1)) << 20));
        endcase
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
